uart_tx: RTL and testbench

- UART transmitter: serialises one byte per valid/ready handshake onto a single TX line.
- Frame format is 8N1: start bit, 8 data bits LSB first, stop bit.
- Bit time is set by a clocks-per-bit parameter.
- Sits between a byte-stream producer (e.g. a FIFO or control FSM) and the board TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data bits).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 69;

  // Width of a counter that spans 0..clks-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake between a producer and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, wraps itself, tick on the last count.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned  W    = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: restart at every bit boundary or when held clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx
);

  localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic baud_clr;
  logic baud_tick;

  // Counter held at zero while idle so the start bit is exactly one bit time.
  assign baud_clr = (state_q == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  assign tx        = tx_q;
  assign bus.ready = ready_q;

  // Next state and next registered outputs; tx/ready are computed one edge ahead.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (bus.valid && ready_q) begin
          state_d  = START;
          shift_d  = bus.data;
          idx_d    = '0;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^bus.data;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // tx leads the shift by one bit: it takes the bit about to reach position 0.
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, shift register and output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (69 and 2 clocks per bit)
// share stimulus and are compared every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned N0 = 69;
  localparam int unsigned N1 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       tx0, tx1;

  uart_tx_if bus0();
  uart_tx_if bus1();
  assign bus0.data  = data;
  assign bus0.valid = valid;
  assign bus1.data  = data;
  assign bus1.valid = valid;

  uart_tx #(.CLKS_PER_BIT(N0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .tx(tx0));
  uart_tx #(.CLKS_PER_BIT(N1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .tx(tx1));

  // 8 MHz clock
  always #62.5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a frame is a list of bit levels, each lasting n clocks.
  int unsigned nbit [2] = '{N0, N1};
  int          rem  [2];
  logic [10:0] frm  [2];
  logic        exp_tx  [2];
  logic        exp_rdy [2];

  function automatic logic [10:0] build_frame(input logic [7:0] d);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    f[FRAME_BITS-1] = 1'b1;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; exp_tx[i] = 1'b1; exp_rdy[i] = 1'b0;
    end
  endtask

  // Outputs after a rising edge, given inputs held before it.
  task automatic model_edge();
    int total;
    for (int i = 0; i < 2; i++) begin
      total = int'(FRAME_BITS * nbit[i]);
      if (!rst) begin
        rem[i] = 0; exp_tx[i] = 1'b1; exp_rdy[i] = 1'b0;
      end else begin
        if (valid && exp_rdy[i]) begin
          frm[i] = build_frame(data);
          rem[i] = total;
        end
        if (rem[i] > 0) begin
          exp_tx[i]  = frm[i][(total - rem[i]) / int'(nbit[i])];
          rem[i]     = rem[i] - 1;
          exp_rdy[i] = 1'b0;
        end else begin
          exp_tx[i]  = 1'b1;
          exp_rdy[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("tx0",  {31'd0, tx0},        {31'd0, exp_tx[0]});
    check("rdy0", {31'd0, bus0.ready}, {31'd0, exp_rdy[0]});
    check("tx1",  {31'd0, tx1},        {31'd0, exp_tx[1]});
    check("rdy1", {31'd0, bus1.ready}, {31'd0, exp_rdy[1]});
  endtask

  // Assert reset between edges and confirm outputs react without a clock.
  task automatic assert_rst();
    rst = 1'b0;
    #1;
    model_reset();
    check("async_tx0",  {31'd0, tx0},        32'd1);
    check("async_rdy0", {31'd0, bus0.ready}, 32'd0);
    check("async_tx1",  {31'd0, tx1},        32'd1);
    check("async_rdy1", {31'd0, bus1.ready}, 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!bus0.ready && k < 3000) begin
      step();
      k++;
    end
    check(tag, {31'd0, bus0.ready}, 32'd1);
  endtask

  initial begin
    int   cnt;
    int   last_rise;
    int   hi_run;
    logic prev;
    logic r;

    // Reset
    #5;
    model_reset();
    rst = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    check("rdy_after_release", {31'd0, bus0.ready}, 32'd1);

    // Single byte 0xAB, one-cycle valid: ready low for exactly one frame
    data  = 8'hAB;
    valid = 1'b1;
    step();
    valid = 1'b0;
    cnt   = 0;
    while (!bus0.ready && cnt < 3000) begin
      cnt++;
      step();
    end
    check("frame_len", cnt, FRAME_BITS * N0);

    // valid held high: one-clock ready pulses, frames 10N+1 apart; data changed mid-frame
    valid     = 1'b1;
    last_rise = -1;
    hi_run    = 0;
    prev      = bus0.ready;
    for (int c = 0; c < 2400; c++) begin
      if (c == 1000) data = 8'h00;
      step();
      r = bus0.ready;
      if (r && !prev) begin
        if (last_rise >= 0) check("b2b_gap", cyc - last_rise, FRAME_BITS * N0 + 1);
        last_rise = cyc;
        hi_run    = 0;
      end
      if (r) hi_run++;
      if (!r && prev && last_rise >= 0) check("rdy_pulse", hi_run, 1);
      prev = r;
    end
    valid = 1'b0;
    wait_ready("drain_b2b");

    // Reset during data bit 3, then a clean frame
    data  = 8'($urandom);
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (300) step();
    assert_rst();
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rdy_after_midrst", {31'd0, bus0.ready}, 32'd1);
    data  = 8'h5A;
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_ready("drain_after_rst");

    // Randomized traffic with data churn and occasional resets
    for (int c = 0; c < 20000; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      if ($urandom_range(0, 2999) == 0) begin
        assert_rst();
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b1;
      end
      step();
    end
    valid = 1'b0;
    wait_ready("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
